// File: rtl/mat_coproc_pkg.sv
// mat_coproc_pkg: shared opcodes, ALU op codes, matrix geometry and controller state type
package mat_coproc_pkg;
  localparam int MAT_N = 5;
  localparam int MAT_W = 8;
  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_WRA  = 3'b001,
    OP_WRB  = 3'b010,
    OP_WRE  = 3'b011,
    OP_EXEC = 3'b100,
    OP_READ = 3'b101,
    OP_CLR  = 3'b110,
    OP_RSV  = 3'b111
  } opcode_e;
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_SMUL = 2'b10;
  localparam logic [1:0] ALU_MMUL = 2'b11;
  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_RUN, S_CAPTURE, S_ACK} state_e;
endpackage

// File: rtl/mat_elem_regfile.sv
// mat_elem_regfile: byte-indexed A/B/result matrices with flat outputs and index range check
module mat_elem_regfile
  import mat_coproc_pkg::*;
#(
  parameter int N = MAT_N,
  parameter int W = MAT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             we_a,
  input  logic             we_b,
  input  logic             we_res,
  input  logic [4:0]       idx,
  input  logic [W-1:0]     din,
  input  logic [N*N*W-1:0] res_in,
  output logic [N*N*W-1:0] mat_a,
  output logic [N*N*W-1:0] mat_b,
  output logic [W-1:0]     rd_byte,
  output logic             idx_ok
);
  localparam int NE = N * N;
  logic [NE*W-1:0] res_q;
  logic [4:0]      sel;
  assign idx_ok  = 32'(idx) < NE;
  assign sel     = idx_ok ? idx : 5'd0;
  assign rd_byte = res_q[int'(sel)*W +: W];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mat_a <= '0;
      mat_b <= '0;
      res_q <= '0;
    end else if (clr) begin
      mat_a <= '0;
      mat_b <= '0;
      res_q <= '0;
    end else begin
      if (we_a && idx_ok) mat_a[int'(sel)*W +: W] <= din;
      if (we_b && idx_ok) mat_b[int'(sel)*W +: W] <= din;
      if (we_res) res_q <= res_in;
    end
  end
endmodule

// File: rtl/mat_coproc.sv
// mat_coproc_ctrl: HPS command controller feeding the matrix ALU over a four-phase valid/ack handshake
// Ports: clk/reset_n; cmd, cmd_valid, cmd_ack, rd_data, busy, ovf, err towards the HPS;
// alu_mat_a/b, alu_esc, alu_op, alu_en out to the ALU; alu_mat_o, alu_ovf, alu_done back from it.
module mat_coproc_ctrl
  import mat_coproc_pkg::*;
#(
  parameter int N       = MAT_N,
  parameter int W       = MAT_W,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      cmd,
  input  logic             cmd_valid,
  output logic             cmd_ack,
  output logic [W-1:0]     rd_data,
  output logic             busy,
  output logic             ovf,
  output logic             err,
  output logic [N*N*W-1:0] alu_mat_a,
  output logic [N*N*W-1:0] alu_mat_b,
  output logic [W-1:0]     alu_esc,
  output logic [1:0]       alu_op,
  output logic             alu_en,
  input  logic [N*N*W-1:0] alu_mat_o,
  input  logic             alu_ovf,
  input  logic             alu_done
);
  localparam int CW = $clog2(TIMEOUT);
  state_e        state;
  logic [17:0]   cmd_q;
  logic [CW-1:0] cnt;
  opcode_e       opc;
  logic [4:0]    idx;
  logic [W-1:0]  data;
  logic          dec, idx_ok, bad;
  logic [W-1:0]  rd_byte;
  logic          unused_cmd_bits;
  // only opcode, index, ALU op and data survive the latch; the middle field is don't-care
  assign unused_cmd_bits = ^cmd[21:8];
  assign opc  = opcode_e'(cmd_q[17:15]);
  assign idx  = cmd_q[14:10];
  assign data = cmd_q[W-1:0];
  assign dec  = state == S_DECODE;
  assign bad  = ((opc == OP_WRA || opc == OP_WRB || opc == OP_READ) && !idx_ok) || opc == OP_RSV;
  mat_elem_regfile #(.N(N), .W(W)) u_regs (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (dec && opc == OP_CLR),
    .we_a    (dec && opc == OP_WRA),
    .we_b    (dec && opc == OP_WRB),
    .we_res  (state == S_CAPTURE),
    .idx     (idx),
    .din     (data),
    .res_in  (alu_mat_o),
    .mat_a   (alu_mat_a),
    .mat_b   (alu_mat_b),
    .rd_byte (rd_byte),
    .idx_ok  (idx_ok)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      cmd_q   <= '0;
      cnt     <= '0;
      cmd_ack <= 1'b0;
      rd_data <= '0;
      busy    <= 1'b0;
      ovf     <= 1'b0;
      err     <= 1'b0;
      alu_esc <= '0;
      alu_op  <= '0;
      alu_en  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (cmd_valid) begin
          cmd_q <= {cmd[31:22], cmd[7:0]};
          busy  <= 1'b1;
          state <= S_DECODE;
        end
        S_DECODE: if (opc == OP_EXEC) begin
          alu_op <= cmd_q[9:8];
          alu_en <= 1'b1;
          cnt    <= '0;
          state  <= S_RUN;
        end else begin
          cmd_ack <= 1'b1;
          state   <= S_ACK;
          if (bad) err <= 1'b1;
          if (opc == OP_WRE) alu_esc <= data;
          if (opc == OP_READ && idx_ok) rd_data <= rd_byte;
          if (opc == OP_CLR) begin
            alu_esc <= '0;
            ovf     <= 1'b0;
            err     <= 1'b0;
          end
        end
        S_RUN: if (alu_done) state <= S_CAPTURE;
        else if (cnt == CW'(TIMEOUT - 1)) begin
          alu_en  <= 1'b0;
          err     <= 1'b1;
          cmd_ack <= 1'b1;
          state   <= S_ACK;
        end else cnt <= cnt + 1'b1;
        // ALU output is registered on the done edge, so enable stays up one more cycle
        S_CAPTURE: begin
          ovf     <= alu_ovf;
          alu_en  <= 1'b0;
          cmd_ack <= 1'b1;
          state   <= S_ACK;
        end
        S_ACK: if (!cmd_valid) begin
          cmd_ack <= 1'b0;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mat_coproc_ctrl.sv
// tb_mat_coproc_ctrl: directed table and sequence checks of the matrix coprocessor controller
module tb_mat_coproc_ctrl;
  localparam int TO = 4096;
  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [31:0]  cmd = '0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ack, busy, ovf, err, alu_en;
  logic [7:0]   rd_data, alu_esc;
  logic [1:0]   alu_op;
  logic [199:0] alu_mat_a, alu_mat_b, alu_mat_o;
  logic         alu_ovf, alu_done;
  logic         done_en = 1'b1;
  logic         model_ovf = 1'b0;
  logic         en_clr = 1'b0;
  int           en_cnt = 0;
  int           mcnt;
  int           n_cmp = 0;
  int           n_bad = 0;
  typedef struct {
    logic [31:0] c;
    logic [7:0]  rd;
    logic        er;
    logic [7:0]  esc;
  } vec_t;
  vec_t tbl [11];

  mat_coproc_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ack(cmd_ack),
    .rd_data(rd_data), .busy(busy), .ovf(ovf), .err(err), .alu_mat_a(alu_mat_a),
    .alu_mat_b(alu_mat_b), .alu_esc(alu_esc), .alu_op(alu_op), .alu_en(alu_en),
    .alu_mat_o(alu_mat_o), .alu_ovf(alu_ovf), .alu_done(alu_done)
  );

  always #5 clk = ~clk;

  // ALU model: element-wise add, done pulses after alu_en has been high for three cycles
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcnt <= 0; alu_done <= 1'b0; alu_mat_o <= '0; alu_ovf <= 1'b0;
    end else if (!alu_en) begin
      mcnt <= 0; alu_done <= 1'b0;
    end else begin
      mcnt <= mcnt + 1;
      alu_done <= done_en && mcnt == 2;
      if (done_en && mcnt == 2) begin
        for (int i = 0; i < 25; i++) alu_mat_o[i*8 +: 8] <= alu_mat_a[i*8 +: 8] + alu_mat_b[i*8 +: 8];
        alu_ovf <= model_ovf;
      end
    end
  end

  always @(posedge clk) en_cnt <= en_clr ? 0 : en_cnt + (alu_en ? 1 : 0);

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk(input logic [2:0] op, input logic [4:0] i, input logic [1:0] aop, input logic [7:0] d);
    return {op, i, aop, 14'd0, d};
  endfunction

  task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_cmd(input logic [31:0] c);
    int n;
    @(negedge clk);
    cmd = c;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ack && n < TO + 50) begin @(negedge clk); n++; end
    chk("ack_wait", cmd_ack, 1);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("ack_drop", {cmd_ack, busy}, 0);
  endtask

  task automatic rd_chk(input string nm, input logic [4:0] i, input logic [7:0] exp);
    do_cmd(mk(3'b101, i, 2'b00, 8'h00));
    chk(nm, rd_data, exp);
  endtask

  initial begin
    tbl[0]  = '{mk(3'b001, 5'd25, 2'b00, 8'hAA), 8'h00, 1'b1, 8'h00};
    tbl[1]  = '{mk(3'b110, 5'd0,  2'b00, 8'h00), 8'h00, 1'b0, 8'h00};
    tbl[2]  = '{mk(3'b111, 5'd0,  2'b00, 8'h00), 8'h00, 1'b1, 8'h00};
    tbl[3]  = '{mk(3'b110, 5'd0,  2'b00, 8'h00), 8'h00, 1'b0, 8'h00};
    tbl[4]  = '{mk(3'b101, 5'd31, 2'b00, 8'h00), 8'h00, 1'b1, 8'h00};
    tbl[5]  = '{mk(3'b110, 5'd0,  2'b00, 8'h00), 8'h00, 1'b0, 8'h00};
    tbl[6]  = '{mk(3'b001, 5'd0,  2'b00, 8'h05), 8'h00, 1'b0, 8'h00};
    tbl[7]  = '{mk(3'b010, 5'd0,  2'b00, 8'h03), 8'h00, 1'b0, 8'h00};
    tbl[8]  = '{mk(3'b011, 5'd0,  2'b00, 8'h02), 8'h00, 1'b0, 8'h02};
    tbl[9]  = '{mk(3'b001, 5'd25, 2'b00, 8'hEE), 8'h00, 1'b1, 8'h02};
    tbl[10] = '{mk(3'b000, 5'd0,  2'b00, 8'h00), 8'h00, 1'b1, 8'h02};
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_outs", {cmd_ack, busy, ovf, err, alu_en, alu_op, alu_esc, rd_data}, 0);
    chk("rst_mat_a", alu_mat_a, 0);
    chk("rst_mat_b", alu_mat_b, 0);
    reset_n = 1'b1;
    // non-EXEC commands and error cases
    for (int k = 0; k < 11; k++) begin
      do_cmd(tbl[k].c);
      chk($sformatf("tbl%0d_rd", k), rd_data, tbl[k].rd);
      chk($sformatf("tbl%0d_err", k), err, tbl[k].er);
      chk($sformatf("tbl%0d_esc", k), alu_esc, tbl[k].esc);
    end
    chk("a_after_bad_idx", alu_mat_a, 200'h05);
    chk("b_after_bad_idx", alu_mat_b, 200'h03);
    // load and add
    en_clr = 1'b1; @(negedge clk); en_clr = 1'b0;
    do_cmd(mk(3'b100, 5'd0, 2'b00, 8'h00));
    chk("add_en_cycles", en_cnt, 5);
    chk("add_en_low", alu_en, 0);
    chk("add_op", alu_op, 2'b00);
    chk("add_ovf", ovf, 0);
    chk("add_err_sticky", err, 1);
    rd_chk("add_rd0", 5'd0, 8'h08);
    rd_chk("add_rd1", 5'd1, 8'h00);
    // overflow capture
    do_cmd(mk(3'b001, 5'd24, 2'b00, 8'h7F));
    do_cmd(mk(3'b010, 5'd24, 2'b00, 8'h01));
    model_ovf = 1'b1;
    do_cmd(mk(3'b100, 5'd0, 2'b00, 8'h00));
    chk("ovf_set", ovf, 1);
    rd_chk("ovf_rd24", 5'd24, 8'h80);
    rd_chk("ovf_rd0", 5'd0, 8'h08);
    // handshake: held valid, cmd changed after ack
    @(negedge clk);
    cmd = mk(3'b001, 5'd1, 2'b00, 8'h11);
    cmd_valid = 1'b1;
    @(negedge clk);
    chk("hs_lat1", {cmd_ack, busy}, 2'b01);
    @(negedge clk);
    chk("hs_lat2", {cmd_ack, busy}, 2'b11);
    cmd = mk(3'b001, 5'd1, 2'b00, 8'h22);
    begin
      int hi = 0;
      repeat (20) begin @(negedge clk); hi += cmd_ack ? 1 : 0; end
      chk("hs_ack_held", hi, 20);
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("hs_drop", {cmd_ack, busy}, 2'b00);
    repeat (3) @(negedge clk);
    chk("hs_once", alu_mat_a[15:8], 8'h11);
    // clear
    do_cmd(mk(3'b110, 5'd0, 2'b00, 8'h00));
    chk("clr_flags", {ovf, err}, 2'b00);
    chk("clr_mats", {alu_mat_a, alu_mat_b, alu_esc}, 0);
    rd_chk("clr_rd0", 5'd0, 8'h00);
    rd_chk("clr_rd24", 5'd24, 8'h00);
    // timeout leaves result and ovf alone
    model_ovf = 1'b0;
    do_cmd(mk(3'b001, 5'd0, 2'b00, 8'h05));
    do_cmd(mk(3'b010, 5'd0, 2'b00, 8'h03));
    do_cmd(mk(3'b100, 5'd0, 2'b00, 8'h00));
    rd_chk("to_pre_rd0", 5'd0, 8'h08);
    chk("to_pre_err", err, 0);
    done_en = 1'b0;
    en_clr = 1'b1; @(negedge clk); en_clr = 1'b0;
    do_cmd(mk(3'b100, 5'd0, 2'b11, 8'h00));
    chk("to_run_cycles", en_cnt, TO);
    chk("to_err", err, 1);
    chk("to_en_low", alu_en, 0);
    chk("to_op", alu_op, 2'b11);
    chk("to_ovf", ovf, 0);
    rd_chk("to_rd0", 5'd0, 8'h08);
    // reset in the middle of RUN
    @(negedge clk);
    cmd = mk(3'b100, 5'd0, 2'b00, 8'h00);
    cmd_valid = 1'b1;
    repeat (10) @(negedge clk);
    chk("mid_en_high", alu_en, 1);
    reset_n = 1'b0;
    cmd_valid = 1'b0;
    #1;
    chk("mid_rst_outs", {alu_en, cmd_ack, err, busy, ovf}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    chk("mid_rst_mats", {alu_mat_a, alu_mat_b}, 0);
    done_en = 1'b1;
    rd_chk("mid_rst_rd0", 5'd0, 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
